// File: rtl/ddr_trn_pkg.sv
// Shared types and defaults for the DDR lane delay trainer.
// Holds the trainer state encoding and the default delay-tap counter width.
package ddr_trn_pkg;

  localparam int TAP_W_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLEAR,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CENTER,
    ST_RETURN,
    ST_FINISH
  } dly_trn_state_t;

endpackage

// File: rtl/ddr_dqs_win_track.sv
// Tracks the currently open passing run and the widest run seen so far during a tap sweep.
// A closed run replaces the best window only when strictly wider, so the first of equal windows wins.
module ddr_dqs_win_track #(
  parameter int TAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             pass,
  input  logic             eval,
  input  logic             close,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] run_start_reg;
  logic [TAP_W:0]   run_len_reg;
  logic [TAP_W-1:0] best_start_reg;
  logic [TAP_W:0]   best_len_reg;

  logic [TAP_W-1:0] ext_start;
  logic [TAP_W:0]   ext_len;
  logic [TAP_W-1:0] cand_start;
  logic [TAP_W:0]   cand_len;
  logic             cand_valid;

  // A passing tap extends (or opens) the run; at sweep end that extended run is the candidate.
  always_comb begin
    ext_start  = (run_len_reg == '0) ? tap : run_start_reg;
    ext_len    = run_len_reg + 1'b1;
    cand_start = run_start_reg;
    cand_len   = run_len_reg;
    cand_valid = 1'b0;
    if (pass) begin
      cand_start = ext_start;
      cand_len   = ext_len;
      cand_valid = eval && close;
    end else begin
      cand_valid = eval && (run_len_reg != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start_reg  <= '0;
      run_len_reg    <= '0;
      best_start_reg <= '0;
      best_len_reg   <= '0;
    end else if (init) begin
      run_start_reg  <= '0;
      run_len_reg    <= '0;
      best_start_reg <= '0;
      best_len_reg   <= '0;
    end else if (eval) begin
      if (pass && !close) begin
        run_start_reg <= ext_start;
        run_len_reg   <= ext_len;
      end else begin
        run_len_reg <= '0;
      end
      if (cand_valid && (cand_len > best_len_reg)) begin
        best_start_reg <= cand_start;
        best_len_reg   <= cand_len;
      end
    end
  end

  assign best_start = best_start_reg;
  assign best_len   = best_len_reg;

endmodule

// File: rtl/ddr_dqs_dly_trainer.sv
// DQS/DQ lane delay trainer: sweeps the IOD delay tap, scores each tap with the eye monitor,
// then walks the delay line back to the centre of the widest passing window.
module ddr_dqs_dly_trainer
  import ddr_trn_pkg::*;
#(
  parameter int TAP_W   = TAP_W_DEF,
  parameter int MAX_TAP = 127,
  parameter int SETTLE  = 4,
  parameter int SAMPLE  = 16,
  parameter int MIN_WIN = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  output logic [TAP_W-1:0] TAP_OUT,
  output logic [TAP_W:0]   WIN_WIDTH
);

  localparam int TMR_W = 16;
  localparam logic [TAP_W-1:0] MAX_TAP_V  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W:0]   MIN_WIN_V  = (TAP_W+1)'(MIN_WIN);
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LD  = TMR_W'(SAMPLE - 1);

  dly_trn_state_t   state_reg;
  logic [TAP_W-1:0] tap_reg;
  logic [TAP_W-1:0] centre_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             fail_acc_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             fail_pulse_reg;
  logic             load_reg;
  logic             move_reg;
  logic             dir_reg;
  logic             clear_reg;
  logic [TAP_W:0]   win_width_reg;

  logic             trk_init;
  logic             trk_eval;
  logic             sweep_end;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;

  assign trk_init  = (state_reg == ST_IDLE) && START;
  assign trk_eval  = (state_reg == ST_EVAL);
  assign sweep_end = (tap_reg >= MAX_TAP_V) || DELAY_LINE_OUT_OF_RANGE;

  ddr_dqs_win_track #(
    .TAP_W (TAP_W)
  ) u_win_track (
    .clk        (FAB_CLK),
    .rst_n      (ARST_N),
    .init       (trk_init),
    .pass       (!fail_acc_reg),
    .eval       (trk_eval),
    .close      (sweep_end),
    .tap        (tap_reg),
    .best_start (best_start),
    .best_len   (best_len)
  );

  // Moves are two-phase (direction settled, then pulse), so MOVE never fires on back-to-back cycles.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_reg      <= ST_IDLE;
      tap_reg        <= '0;
      centre_reg     <= '0;
      timer_reg      <= '0;
      fail_acc_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fail_pulse_reg <= 1'b0;
      load_reg       <= 1'b0;
      move_reg       <= 1'b0;
      dir_reg        <= 1'b0;
      clear_reg      <= 1'b0;
      win_width_reg  <= '0;
    end else begin
      load_reg       <= 1'b0;
      move_reg       <= 1'b0;
      clear_reg      <= 1'b0;
      done_reg       <= 1'b0;
      fail_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            state_reg     <= ST_LOAD;
            busy_reg      <= 1'b1;
            load_reg      <= 1'b1;
            dir_reg       <= 1'b1;
            tap_reg       <= '0;
            win_width_reg <= '0;
          end
        end
        ST_LOAD: begin
          tap_reg   <= '0;
          timer_reg <= SETTLE_LD;
          state_reg <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_reg == '0) begin
            clear_reg <= 1'b1;
            state_reg <= ST_CLEAR;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        ST_CLEAR: begin
          timer_reg    <= SAMPLE_LD;
          fail_acc_reg <= 1'b0;
          state_reg    <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          fail_acc_reg <= fail_acc_reg | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
          if (timer_reg == '0) begin
            state_reg <= ST_EVAL;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        ST_EVAL: begin
          state_reg <= sweep_end ? ST_CENTER : ST_STEP;
        end
        ST_STEP: begin
          if (!move_reg) begin
            move_reg <= 1'b1;
          end else begin
            tap_reg   <= tap_reg + 1'b1;
            timer_reg <= SETTLE_LD;
            state_reg <= ST_SETTLE;
          end
        end
        ST_CENTER: begin
          win_width_reg <= best_len;
          if (best_len < MIN_WIN_V) begin
            fail_pulse_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= ST_FINISH;
          end else begin
            centre_reg <= best_start + TAP_W'((best_len - 1'b1) >> 1);
            dir_reg    <= 1'b0;
            state_reg  <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          if (move_reg) begin
            tap_reg <= tap_reg - 1'b1;
          end else if (tap_reg <= centre_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_FINISH;
          end else begin
            move_reg <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY                    = busy_reg;
  assign DONE                    = done_reg;
  assign FAIL                    = fail_pulse_reg;
  assign DELAY_LINE_LOAD         = load_reg;
  assign DELAY_LINE_MOVE         = move_reg;
  assign DELAY_LINE_DIRECTION    = dir_reg;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_reg;
  assign TAP_OUT                 = tap_reg;
  assign WIN_WIDTH               = win_width_reg;

endmodule

// File: tb/tb_ddr_dqs_dly_trainer.sv
// Directed bench for the lane delay trainer: a sticky eye-monitor model driven by per-tap pass windows,
// pulse counters on the delay-line pins, and hand-computed centre/width expectations.
module tb_ddr_dqs_dly_trainer;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       START   = 1'b0;
  logic       BUSY, DONE, FAIL;
  logic       LOAD, MOVE, DIR, CLEAR;
  logic       OOR;
  logic       early_reg = 1'b0;
  logic       late_reg  = 1'b0;
  logic [7:0] TAP_OUT;
  logic [8:0] WIN_WIDTH;

  int lo1 = 1000, hi1 = -1, lo2 = 1000, hi2 = -1, oor_tap = 1000;
  int n_inc, n_dec, n_load, n_done, n_fail, n_viol;
  int n_pass = 0, n_total = 0;
  logic prev_move = 1'b0, prev_dir = 1'b0;

  ddr_dqs_dly_trainer #(
    .TAP_W(8), .MAX_TAP(127), .SETTLE(4), .SAMPLE(16), .MIN_WIN(4)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .START                   (START),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .FAIL                    (FAIL),
    .DELAY_LINE_LOAD         (LOAD),
    .DELAY_LINE_MOVE         (MOVE),
    .DELAY_LINE_DIRECTION    (DIR),
    .DELAY_LINE_OUT_OF_RANGE (OOR),
    .EYE_MONITOR_CLEAR_FLAGS (CLEAR),
    .EYE_MONITOR_EARLY       (early_reg),
    .EYE_MONITOR_LATE        (late_reg),
    .TAP_OUT                 (TAP_OUT),
    .WIN_WIDTH               (WIN_WIDTH)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  function automatic bit tap_pass(int t);
    return ((t >= lo1) && (t <= hi1)) || ((t >= lo2) && (t <= hi2));
  endfunction

  assign OOR = (int'(TAP_OUT) >= oor_tap);

  // Sticky flags: set while the tap is outside the eye, cleared only by the clear pulse.
  always @(posedge FAB_CLK) begin
    if (CLEAR) begin
      early_reg <= 1'b0;
      late_reg  <= 1'b0;
    end else if (!tap_pass(int'(TAP_OUT))) begin
      if (TAP_OUT[0]) late_reg <= 1'b1;
      else            early_reg <= 1'b1;
    end
  end

  always @(negedge FAB_CLK) begin
    if (MOVE && DIR)  n_inc++;
    if (MOVE && !DIR) n_dec++;
    if (LOAD) n_load++;
    if (DONE) n_done++;
    if (FAIL) n_fail++;
    if (MOVE && prev_move) n_viol++;
    if ((int'(LOAD) + int'(MOVE) + int'(CLEAR)) > 1) n_viol++;
    if (MOVE && (DIR != prev_dir)) n_viol++;
    prev_move = MOVE;
    prev_dir  = DIR;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_counts();
    n_inc = 0; n_dec = 0; n_load = 0; n_done = 0; n_fail = 0; n_viol = 0;
  endtask

  function automatic int all_outs();
    return int'({BUSY, DONE, FAIL, LOAD, MOVE, DIR, CLEAR, TAP_OUT, WIN_WIDTH});
  endfunction

  task automatic run_case(input string name, input int a, input int b, input int c, input int d,
                          input int o, input int e_done, input int e_fail, input int e_tap,
                          input int e_width, input int e_inc, input int e_dec);
    bit fin;
    lo1 = a; hi1 = b; lo2 = c; hi2 = d; oor_tap = o;
    clear_counts();
    @(negedge FAB_CLK); START = 1'b1;
    @(negedge FAB_CLK); START = 1'b0;
    chk({name, "_busy_rise"}, int'(BUSY), 1);
    chk({name, "_load_first"}, int'(LOAD), 1);
    repeat (30) @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK); START = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 8000 && !fin; i++) begin
      @(negedge FAB_CLK);
      if ((n_done + n_fail) > 0) fin = 1'b1;
    end
    chk({name, "_finished"}, int'(fin), 1);
    repeat (3) @(negedge FAB_CLK);
    chk({name, "_done"},  n_done, e_done);
    chk({name, "_fail"},  n_fail, e_fail);
    chk({name, "_tap"},   int'(TAP_OUT), e_tap);
    chk({name, "_width"}, int'(WIN_WIDTH), e_width);
    chk({name, "_inc"},   n_inc, e_inc);
    chk({name, "_dec"},   n_dec, e_dec);
    chk({name, "_loads"}, n_load, 1);
    chk({name, "_proto"}, n_viol, 0);
    chk({name, "_busy_low"}, int'(BUSY), 0);
    $display("case %s: done=%0d fail=%0d tap=%0d width=%0d inc=%0d dec=%0d",
             name, n_done, n_fail, TAP_OUT, WIN_WIDTH, n_inc, n_dec);
  endtask

  initial begin
    bit hit;
    clear_counts();
    repeat (3) @(negedge FAB_CLK);
    chk("reset_outputs", all_outs(), 0);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    chk("post_reset_outputs", all_outs(), 0);

    run_case("single",  20, 39, 1000, -1, 1000, 1, 0, 29, 20, 127, 98);
    run_case("two_win", 10, 14, 50, 59,   1000, 1, 0, 54, 10, 127, 73);
    run_case("equal",   10, 17, 40, 47,   1000, 1, 0, 13, 8,  127, 114);
    run_case("narrow",  30, 32, 1000, -1, 1000, 0, 1, 127, 3, 127, 0);
    run_case("oor",     50, 127, 1000, -1, 60,  1, 0, 55, 11, 60, 5);

    // Abort a sweep at tap 40 with the asynchronous reset.
    lo1 = 20; hi1 = 39; lo2 = 1000; hi2 = -1; oor_tap = 1000;
    @(negedge FAB_CLK); START = 1'b1;
    @(negedge FAB_CLK); START = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge FAB_CLK);
      if (TAP_OUT == 8'd40) hit = 1'b1;
    end
    chk("reach_tap40", int'(hit), 1);
    ARST_N = 1'b0;
    #1;
    chk("abort_outputs", all_outs(), 0);
    @(negedge FAB_CLK);
    chk("abort_hold", all_outs(), 0);
    ARST_N = 1'b1;
    clear_counts();
    repeat (10) @(negedge FAB_CLK);
    chk("abort_no_moves", n_inc + n_dec, 0);
    chk("abort_no_loads", n_load, 0);
    chk("abort_idle", int'(BUSY), 0);

    run_case("rerun",   20, 39, 1000, -1, 1000, 1, 0, 29, 20, 127, 98);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
